rr_oh_arbiter: RTL and testbench

Round-robin arbiter that turns a request vector plus an internal last-grant index into a one-hot grant and its matching index. It is the index-to-one-hot counterpart of the one-hot-to-index encoder: the stored priority pointer, an index, is decoded to a one-hot priority mask, and the winning one-hot grant is emitted together with its index. It sits in front of shared resources, such as thread select and cache-miss queue issue, so that consumers can use either `grant_oh` or `grant_idx` without a separate encoder.

---
 rtl/rr_oh_arbiter.sv | 129 ++++++++++++
 tb/tb_rr_oh_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/rr_oh_arbiter.sv
// ---------------------------------------------------------------------------
// rr_oh_arbiter
//
// Round-robin arbiter. A stored last-grant index is turned into a priority
// start position, decoded to a one-hot mask, and a masked double-width
// lowest-set-bit search picks the winner. The winner is presented both as a
// one-hot vector and as a binary index, so consumers need no extra encoder.
//
// Parameters:
//   NUM_REQ       number of requesters (>= 2, any value)
//   IDX_WIDTH     width of index fields, defaults to $clog2(NUM_REQ)
//
// Ports:
//   i_clk         clock, all state changes on the rising edge
//   i_reset       synchronous active-high reset
//   i_request     request vector, bit i = requester i wants the resource
//   i_update_en   consumer accepted the presented grant; advance pointer
//   o_grant_oh    one-hot winner (all zero when nothing granted)
//   o_grant_idx   binary index of the winner (0 when no grant)
//   o_grant_valid OR of o_grant_oh
//
// Build option:
//   RR_OH_ARBITER_OUT_REG_EN  when defined, grant outputs are registered and
//                             appear one cycle after the request.
// ---------------------------------------------------------------------------
module rr_oh_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NUM_REQ-1:0]   i_request,
    input  logic                 i_update_en,
    output logic [NUM_REQ-1:0]   o_grant_oh,
    output logic [IDX_WIDTH-1:0] o_grant_idx,
    output logic                 o_grant_valid
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX_MAX = IDX_WIDTH'(NUM_REQ - 1);

    // Priority start follows the last grant and wraps at NUM_REQ-1, not at
    // the all-ones index value, so non-power-of-two sizes never hit a ghost.
    function automatic logic [IDX_WIDTH-1:0] nextPtr(input logic [IDX_WIDTH-1:0] last);
        return (last == LAST_IDX_MAX) ? '0 : last + IDX_WIDTH'(1);
    endfunction

    // The upper copy of the request vector is unmasked and the lower copy
    // only keeps bits at or above the priority start. The lowest set bit of
    // the concatenation is therefore the first requester in round-robin
    // order; folding the two halves back together gives the one-hot winner.
    function automatic logic [NUM_REQ-1:0] selectOh(input logic [NUM_REQ-1:0]   req,
                                                    input logic [IDX_WIDTH-1:0] ptr);
        logic [NUM_REQ-1:0]   prioOh;
        logic [NUM_REQ-1:0]   upperMask;
        logic [2*NUM_REQ-1:0] dbl;
        logic [2*NUM_REQ-1:0] dblOh;
        prioOh    = NUM_REQ'(1) << ptr;
        upperMask = ~(prioOh - NUM_REQ'(1));
        dbl       = {req, req & upperMask};
        dblOh     = dbl & (~dbl + (2*NUM_REQ)'(1));
        return dblOh[NUM_REQ-1:0] | dblOh[2*NUM_REQ-1:NUM_REQ];
    endfunction

    function automatic logic [IDX_WIDTH-1:0] ohToIdx(input logic [NUM_REQ-1:0] oh);
        logic [IDX_WIDTH-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_WIDTH'(i);
            end
        end
        return idx;
    endfunction

    logic [IDX_WIDTH-1:0] r_lastIdx;
    logic [NUM_REQ-1:0]   w_presOh;
    logic [IDX_WIDTH-1:0] w_presIdx;
    logic                 w_presValid;
    logic [IDX_WIDTH-1:0] w_postLast;

    // Pointer after this edge: the presented grant if it was accepted.
    // An accept while nothing is granted is simply ignored.
    assign w_postLast = (i_update_en && w_presValid) ? w_presIdx : r_lastIdx;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lastIdx <= LAST_IDX_MAX;
        end else begin
            r_lastIdx <= w_postLast;
        end
    end

`ifdef RR_OH_ARBITER_OUT_REG_EN
    logic [NUM_REQ-1:0]   r_grantOh;
    logic [IDX_WIDTH-1:0] r_grantIdx;
    logic                 r_grantValid;
    logic [NUM_REQ-1:0]   w_nextOh;

    // Next presented grant is computed against the post-update pointer so an
    // accepted requester cannot win the very next presented grant while
    // others are still requesting.
    assign w_nextOh = selectOh(i_request, nextPtr(w_postLast));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_grantOh    <= '0;
            r_grantIdx   <= '0;
            r_grantValid <= 1'b0;
        end else begin
            r_grantOh    <= w_nextOh;
            r_grantIdx   <= ohToIdx(w_nextOh);
            r_grantValid <= |w_nextOh;
        end
    end

    assign w_presOh    = r_grantOh;
    assign w_presIdx   = r_grantIdx;
    assign w_presValid = r_grantValid;
`else
    assign w_presOh    = selectOh(i_request, nextPtr(r_lastIdx));
    assign w_presIdx   = ohToIdx(w_presOh);
    assign w_presValid = |w_presOh;
`endif

    assign o_grant_oh    = w_presOh;
    assign o_grant_idx   = w_presIdx;
    assign o_grant_valid = w_presValid;

endmodule

// File: tb/tb_rr_oh_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_oh_arbiter
//
// Self-checking bench for rr_oh_arbiter. Two instances run side by side: a
// 4-requester arbiter and a 3-requester one (non-power-of-two wrap). A
// behavioural model tracks the last accepted requester as an integer and
// finds each winner by scanning requesters in round-robin order. Works for
// both the combinational build and the RR_OH_ARBITER_OUT_REG_EN build.
// ---------------------------------------------------------------------------
module tb_rr_oh_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req4;
    logic       upd4;
    logic [3:0] oh4;
    logic [1:0] idx4;
    logic       valid4;
    logic [2:0] req3;
    logic       upd3;
    logic [2:0] oh3;
    logic [1:0] idx3;
    logic       valid3;

    int checks   = 0;
    int failures = 0;

    // Model state: last accepted requester, and the winner currently shown
    // on the registered outputs (-1 means no grant).
    int last4;
    int last3;
    int shown4;
    int shown3;

    always #5 clk = ~clk;

    rr_oh_arbiter #(.NUM_REQ(4)) dut4 (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_request    (req4),
        .i_update_en  (upd4),
        .o_grant_oh   (oh4),
        .o_grant_idx  (idx4),
        .o_grant_valid(valid4)
    );

    rr_oh_arbiter #(.NUM_REQ(3)) dut3 (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_request    (req3),
        .i_update_en  (upd3),
        .o_grant_oh   (oh3),
        .o_grant_idx  (idx3),
        .o_grant_valid(valid3)
    );

    // Round-robin winner: first requester after the last one, wrapping
    // around n; -1 when nobody requests.
    function automatic int refPick(input int n, input logic [3:0] req, input int last);
        for (int k = 1; k <= n; k++) begin
            int j;
            j = (last + k) % n;
            if (req[j]) return j;
        end
        return -1;
    endfunction

    function automatic int presented(input int n, input logic [3:0] req, input int last,
                                     input int shown);
`ifdef RR_OH_ARBITER_OUT_REG_EN
        return shown;
`else
        return refPick(n, req, last);
`endif
    endfunction

    // Advance one model instance across a rising edge.
    task automatic modelEdge(input int n, input logic [3:0] req, input logic upd,
                             input logic rst, inout int last, inout int shown);
        int pres;
        int post;
        pres = presented(n, req, last, shown);
        if (rst) begin
            last  = n - 1;
            shown = -1;
        end else begin
            post  = (upd && pres >= 0) ? pres : last;
            last  = post;
            shown = refPick(n, req, post);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs just after an edge, check mid-cycle, then
    // follow the DUT across the next rising edge.
    task automatic applyStimulus(input string tag, input logic [3:0] r4, input logic u4,
                                 input logic [2:0] r3, input logic u3, input logic rst);
        int p4;
        int p3;
        req4  = r4;
        upd4  = u4;
        req3  = r3;
        upd3  = u3;
        reset = rst;
        @(negedge clk);
        p4 = presented(4, r4, last4, shown4);
        p3 = presented(3, {1'b0, r3}, last3, shown3);
        checkOutput({tag, " oh4"},    32'(oh4),    (p4 < 0) ? 32'd0 : (32'd1 << p4));
        checkOutput({tag, " idx4"},   32'(idx4),   (p4 < 0) ? 32'd0 : 32'(p4));
        checkOutput({tag, " valid4"}, 32'(valid4), (p4 < 0) ? 32'd0 : 32'd1);
        checkOutput({tag, " oh3"},    32'(oh3),    (p3 < 0) ? 32'd0 : (32'd1 << p3));
        checkOutput({tag, " idx3"},   32'(idx3),   (p3 < 0) ? 32'd0 : 32'(p3));
        checkOutput({tag, " valid3"}, 32'(valid3), (p3 < 0) ? 32'd0 : 32'd1);
        @(posedge clk);
        modelEdge(4, r4, u4, rst, last4, shown4);
        modelEdge(3, {1'b0, r3}, u3, rst, last3, shown3);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        req4  = '0;
        upd4  = 1'b0;
        req3  = '0;
        upd3  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        last4  = 3;
        last3  = 2;
        shown4 = -1;
        shown3 = -1;

        // Reset default: requester 0 wins and holds with no accepts.
        for (int i = 0; i < 3; i++) applyStimulus("resetDefault", 4'b1111, 1'b0, 3'b111, 1'b0, 1'b0);

        // Rotation with everyone requesting and every grant accepted.
        for (int i = 0; i < 6; i++) applyStimulus("rotation", 4'b1111, 1'b1, 3'b111, 1'b1, 1'b0);

        // Sparse requests: accept requester 1, then skip to 3, then wrap to 0.
        applyStimulus("resync", 4'b0000, 1'b0, 3'b000, 1'b0, 1'b1);
        applyStimulus("sparse", 4'b0010, 1'b1, 3'b010, 1'b1, 1'b0);
        applyStimulus("sparse", 4'b0010, 1'b1, 3'b010, 1'b1, 1'b0);
        applyStimulus("sparse", 4'b1001, 1'b1, 3'b101, 1'b1, 1'b0);
        applyStimulus("sparse", 4'b1001, 1'b1, 3'b101, 1'b1, 1'b0);
        applyStimulus("sparse", 4'b1001, 1'b0, 3'b101, 1'b0, 1'b0);
        applyStimulus("sparse", 4'b1001, 1'b0, 3'b101, 1'b0, 1'b0);

        // Single requester always wins whatever the pointer.
        for (int i = 0; i < 4; i++) applyStimulus("single", 4'b0100, 1'b1, 3'b100, 1'b1, 1'b0);

        // Idle cycles with ignored accepts, then the same winner as before.
        applyStimulus("preIdle", 4'b1111, 1'b1, 3'b111, 1'b1, 1'b0);
        applyStimulus("idle", 4'b0000, 1'b1, 3'b000, 1'b1, 1'b0);
        applyStimulus("idle", 4'b0000, 1'b1, 3'b000, 1'b1, 1'b0);
        applyStimulus("idle", 4'b0000, 1'b1, 3'b000, 1'b1, 1'b0);
        applyStimulus("postIdle", 4'b1111, 1'b0, 3'b111, 1'b0, 1'b0);
        applyStimulus("postIdle", 4'b1111, 1'b0, 3'b111, 1'b0, 1'b0);

        // Reset in the middle of a rotating stream overrides the accept.
        applyStimulus("midReset", 4'b0000, 1'b0, 3'b000, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus("midReset", 4'b1111, 1'b1, 3'b111, 1'b1, 1'b0);
        applyStimulus("midReset", 4'b1111, 1'b1, 3'b111, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus("midReset", 4'b1111, 1'b1, 3'b111, 1'b1, 1'b0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            applyStimulus("random",
                          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                          3'($urandom_range(0, 7)),  1'($urandom_range(0, 1)),
                          ($urandom_range(0, 49) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
